// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared states, memory command encodings and port indices for mem_arbiter
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, CMD, CAPT, RESP} state_t;
  localparam logic [1:0] MEM_CMD_IDLE = 2'b11;
  localparam logic [1:0] MEM_CMD_WR = 2'b01;
  localparam logic [1:0] MEM_CMD_RD = 2'b10;
  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_LS = 1'b1;
endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// rr_arb2: combinational two-way grant selector, round-robin or fixed priority on a tie
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  input  logic       fixed_prio,
  output logic       gnt_valid,
  output logic       gnt_id
);
  always_comb begin
    gnt_valid = |req;
    gnt_id = &req ? (fixed_prio ? PORT_IF : ~last_grant) : (req[1] ? PORT_LS : PORT_IF);
  end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: grants one of two ports at a time and sequences main_memory commands
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int FIXED_PRIO = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_ack,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_ack,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              mem_write,
  output logic              mem_read,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              grant_id
);
  state_t state, state_n;
  logic last_grant, we_q, gnt_valid, gnt_id, sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  rr_arb2 u_arb (
    .req       ({p1_req, p0_req}),
    .last_grant(last_grant),
    .fixed_prio(FIXED_PRIO != 0),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );
  always_comb begin
    sel_we = gnt_id ? p1_we : p0_we;
    sel_addr = gnt_id ? p1_addr : p0_addr;
    sel_wdata = gnt_id ? p1_wdata : p0_wdata;
    state_n = state == IDLE ? (gnt_valid ? CMD : IDLE) :
              state == CMD  ? (we_q ? RESP : CAPT) :
              state == CAPT ? RESP : IDLE;
  end
  // outputs are registered from the next state so they line up with it
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      {mem_write, mem_read} <= MEM_CMD_IDLE;
      mem_addr <= '0;
      mem_wdata <= '0;
      p0_ack <= 1'b0;
      p1_ack <= 1'b0;
      p0_rdata <= '0;
      p1_rdata <= '0;
      busy <= 1'b0;
      grant_id <= 1'b0;
      last_grant <= 1'b1;
      we_q <= 1'b0;
    end else begin
      state <= state_n;
      {mem_write, mem_read} <= state_n == CMD ? (sel_we ? MEM_CMD_WR : MEM_CMD_RD) : MEM_CMD_IDLE;
      busy <= state_n != IDLE;
      p0_ack <= state_n == RESP && grant_id == PORT_IF;
      p1_ack <= state_n == RESP && grant_id == PORT_LS;
      if (state == IDLE && gnt_valid) begin
        grant_id <= gnt_id;
        last_grant <= gnt_id;
        we_q <= sel_we;
        mem_addr <= sel_addr;
        mem_wdata <= sel_wdata;
      end
      if (state == CAPT && grant_id == PORT_IF) p0_rdata <= mem_rdata;
      if (state == CAPT && grant_id == PORT_LS) p1_rdata <= mem_rdata;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: random and directed traffic against a transaction-level reference model
module tb_mem_arbiter;
  logic clk, rst;
  logic [1:0] req, we;
  logic [15:0] addr [2];
  logic [15:0] wdata [2];
  logic p0_ack, p1_ack, mem_write, mem_read, busy, grant_id;
  logic [15:0] p0_rdata, p1_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [15:0] mem [0:65535];
  logic [15:0] ref_mem [0:65535];
  logic [15:0] m_rdata [2];
  logic m_last;
  int n_tests = 0, n_fail = 0;
  logic f_rst;
  logic [1:0] f_req;
  logic [15:0] f_const, f_zero;
  logic f_ack0, f_ack1, f_mw, f_mr, f_busy, f_gid;
  logic [15:0] f_rd0, f_rd1, f_addr, f_wdata;

  mem_arbiter #(.ADDR_W(16), .DATA_W(16), .FIXED_PRIO(0)) dut (
    .clk(clk), .rst(rst),
    .p0_req(req[0]), .p0_we(we[0]), .p0_addr(addr[0]), .p0_wdata(wdata[0]),
    .p0_ack(p0_ack), .p0_rdata(p0_rdata),
    .p1_req(req[1]), .p1_we(we[1]), .p1_addr(addr[1]), .p1_wdata(wdata[1]),
    .p1_ack(p1_ack), .p1_rdata(p1_rdata),
    .mem_write(mem_write), .mem_read(mem_read), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy), .grant_id(grant_id)
  );

  mem_arbiter #(.ADDR_W(16), .DATA_W(16), .FIXED_PRIO(1)) u_fix (
    .clk(clk), .rst(f_rst),
    .p0_req(f_req[0]), .p0_we(1'b0), .p0_addr(f_zero), .p0_wdata(f_zero),
    .p0_ack(f_ack0), .p0_rdata(f_rd0),
    .p1_req(f_req[1]), .p1_we(1'b0), .p1_addr(f_zero), .p1_wdata(f_zero),
    .p1_ack(f_ack1), .p1_rdata(f_rd1),
    .mem_write(f_mw), .mem_read(f_mr), .mem_addr(f_addr),
    .mem_wdata(f_wdata), .mem_rdata(f_const), .busy(f_busy), .grant_id(f_gid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // stand-in for main_memory: writes on 01, registered read data on 10
  always @(posedge clk) begin
    if ({mem_write, mem_read} == 2'b01) mem[mem_addr] <= mem_wdata;
    else if ({mem_write, mem_read} == 2'b10) mem_rdata <= mem[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] rdata_of(input int p);
    return p == 1 ? p1_rdata : p0_rdata;
  endfunction

  task automatic issue(input int p, input logic w, input logic [15:0] a, input logic [15:0] d);
    we[p] = w;
    addr[p] = a;
    wdata[p] = d;
    req[p] = 1'b1;
  endtask

  // entered at a negedge of an IDLE cycle with requests already driven
  task automatic do_round(output logic w);
    logic [15:0] exp_rd;
    int lat;
    check("idle_cmd", 32'({mem_write, mem_read}), 32'(2'b11));
    check("idle_busy", 32'(busy), 0);
    check("idle_ack", 32'({p1_ack, p0_ack}), 0);
    w = 1'b0;
    if (req == 2'b00) begin
      @(negedge clk);
      return;
    end
    w = &req ? ~m_last : req[1];
    m_last = w;
    lat = we[w] ? 2 : 3;
    exp_rd = ref_mem[addr[w]];
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      check("busy", 32'(busy), 1);
      check("grant_id", 32'(grant_id), 32'(w));
      check("cmd", 32'({mem_write, mem_read}), k == 1 ? (we[w] ? 32'(2'b01) : 32'(2'b10)) : 32'(2'b11));
      if (k == 1) check("mem_addr", 32'(mem_addr), 32'(addr[w]));
      if (k == 1 && we[w]) check("mem_wdata", 32'(mem_wdata), 32'(wdata[w]));
      check("p0_ack", 32'(p0_ack), 32'(k == lat && w == 1'b0));
      check("p1_ack", 32'(p1_ack), 32'(k == lat && w == 1'b1));
      for (int p = 0; p < 2; p++)
        check(p == 1 ? "p1_rdata" : "p0_rdata", 32'(rdata_of(p)),
              32'((k == lat && !we[w] && p == int'(w)) ? exp_rd : m_rdata[p]));
    end
    if (we[w]) ref_mem[addr[w]] = wdata[w];
    else m_rdata[w] = exp_rd;
    req[w] = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    logic w;
    for (int a = 0; a < 65536; a++) begin
      mem[a] = 16'h2BCD + 16'(a * 3);
      ref_mem[a] = 16'h2BCD + 16'(a * 3);
    end
    rst = 1'b1;
    req = 2'b00;
    we = 2'b00;
    addr[0] = '0; addr[1] = '0; wdata[0] = '0; wdata[1] = '0;
    m_last = 1'b1;
    m_rdata[0] = '0; m_rdata[1] = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("rst_cmd", 32'({mem_write, mem_read}), 32'(2'b11));
      check("rst_ack", 32'({p1_ack, p0_ack}), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_rdata", 32'({p1_rdata, p0_rdata}), 0);
      check("rst_grant", 32'(grant_id), 0);
    end
    // both ports reading back-to-back alternate starting with port 0
    issue(0, 1'b0, 16'h0003, 16'h0);
    issue(1, 1'b0, 16'h0005, 16'h0);
    for (int i = 0; i < 6; i++) begin
      do_round(w);
      check("rr_order", 32'(grant_id), 32'(i % 2));
      issue(int'(w), 1'b0, 16'(i + 7), 16'h0);
    end
    req = 2'b00;
    issue(1, 1'b1, 16'h0010, 16'hBEEF);
    do_round(w);
    check("beef_mem", 32'(mem[16'h0010]), 32'(16'hBEEF));
    issue(0, 1'b0, 16'h0000, 16'h0);
    do_round(w);
    check("read0_held", 32'(p0_rdata), 32'(16'h2BCD));
    issue(1, 1'b1, 16'h0020, 16'h1234);
    do_round(w);
    issue(0, 1'b0, 16'h0020, 16'h0);
    do_round(w);
    check("wr_rd_p0", 32'(p0_rdata), 32'(16'h1234));
    // reset during CAPT of a port 0 read
    issue(0, 1'b0, 16'h0031, 16'h0);
    @(negedge clk);
    check("mid_cmd_rd", 32'({mem_write, mem_read}), 32'(2'b10));
    @(negedge clk);
    check("mid_capt_cmd", 32'({mem_write, mem_read}), 32'(2'b11));
    rst = 1'b1;
    req = 2'b00;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_cmd", 32'({mem_write, mem_read}), 32'(2'b11));
    check("mid_rst_ack", 32'({p1_ack, p0_ack}), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_rdata", 32'({p1_rdata, p0_rdata}), 0);
    m_last = 1'b1;
    m_rdata[0] = '0; m_rdata[1] = '0;
    issue(0, 1'b0, 16'h0031, 16'h0);
    do_round(w);
    check("after_rst_rd", 32'(p0_rdata), 32'(16'h2BCD + 16'h0093));
    for (int i = 0; i < 300; i++) begin
      for (int p = 0; p < 2; p++)
        if (!req[p] && $urandom_range(0, 2) != 0)
          issue(p, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 15)), 16'($urandom));
      do_round(w);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // fixed priority: port 0 wins every round while both hold reads
  initial begin
    f_rst = 1'b1;
    f_req = 2'b00;
    f_zero = '0;
    f_const = 16'h5A5A;
    repeat (3) @(negedge clk);
    f_rst = 1'b0;
    f_req = 2'b11;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      check("fix_ack0", 32'(f_ack0), 32'(c % 4 == 3));
      check("fix_ack1", 32'(f_ack1), 0);
      if (c % 4 == 3) check("fix_rdata0", 32'(f_rd0), 32'(16'h5A5A));
    end
    f_req = 2'b00;
  end
endmodule
